// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the 7-segment scan controller and its
// nibble mux / display pins.
interface seg_scan_ctrl_if;
    logic [3:0] nib_in;
    logic [7:0] en_mask;
    logic [7:0] dp_mask;
    logic [2:0] sel;
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output nib_in, en_mask, dp_mask,
        input  sel, anode, seg, dp
    );

    modport slave (
        input  nib_in, en_mask, dp_mask,
        output sel, anode, seg, dp
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with a
// blanking gap between digits to suppress ghosting.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 4
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXC);

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    sel_n;
    logic [7:0]    anode_n;
    logic          dp_n;
    logic [6:0]    seg_n;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state, counter, select and the pin values that follow them.
    // Anode/dp come from next state so they switch on the same edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        sel_n   = bus.sel;
        anode_n = 8'hFF;
        dp_n    = 1'b1;
        seg_n   = hex7(bus.nib_in);
        unique case (state)
            BLANK: begin
                if (cnt == CW'(BLANK_CYC - 1)) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                end
            end
            SCAN: begin
                if (cnt == CW'(REFRESH_DIV - 1)) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    sel_n   = bus.sel + 3'd1;
                end
            end
            default: ;
        endcase
        if (state_n == SCAN) begin
            anode_n[sel_n] = ~bus.en_mask[sel_n];
            dp_n           = ~bus.dp_mask[sel_n];
        end
    end

    // State and output registers; seg tracks nib_in every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BLANK;
            cnt       <= '0;
            bus.sel   <= 3'd0;
            bus.anode <= 8'hFF;
            bus.seg   <= 7'h7F;
            bus.dp    <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bus.sel   <= sel_n;
            bus.anode <= anode_n;
            bus.seg   <= seg_n;
            bus.dp    <= dp_n;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit 7-segment display.
- Drives the 3-bit nibble select into the address/data nibble multiplexer and takes back the selected 4-bit nibble.
- Decodes the nibble to hex segments and drives the digit anodes.
- Inserts a blanking interval between digits to suppress ghosting.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is lit (SCAN length); must be >=2.
- BLANK_CYC, 4: clock cycles all anodes are off between digits (BLANK length); must be >=2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- nib_in  input  4  nibble returned by the nibble mux for the current sel
- en_mask  input  8  per-digit enable; bit i=0 keeps digit i dark
- dp_mask  input  8  per-digit decimal point; bit i=1 lights DP on digit i
- sel  output  3  nibble/digit select to the nibble mux
- anode  output  8  digit anodes, active-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset. It is sampled only on the rising edge of clk.
- All outputs are registered.
- Reset values: state=BLANK, cnt=0, sel=3'd0, anode=8'hFF, seg=7'h7F, dp=1.
- FSM has two states, BLANK and SCAN, plus a cycle counter cnt sized for max(REFRESH_DIV, BLANK_CYC).
- BLANK state:
  - anode=8'hFF and dp=1.
  - cnt increments each cycle.
  - On the cycle cnt==BLANK_CYC-1: next state=SCAN, cnt<=0.
- SCAN state:
  - anode[sel]=~en_mask[sel]; all other anode bits are 1.
  - dp=~dp_mask[sel].
  - cnt increments each cycle.
  - On the cycle cnt==REFRESH_DIV-1: next state=BLANK, cnt<=0, sel<=sel+1.
  - sel wraps 7->0 (3-bit modular).
- anode and dp are registered from next-state/next-sel, so they change on the same edge as the state.
- seg is registered every cycle from decode(nib_in), giving 1-cycle latency from sel.
  - Because BLANK_CYC>=2, seg is settled before any anode asserts.
  - seg is never forced during BLANK.
- Digit period is REFRESH_DIV+BLANK_CYC cycles; full frame is 8 times that.
- After reset: BLANK_CYC cycles of BLANK with sel=0, then digit 0 is lit.
- Hex decode, listed as seg value {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- en_mask and dp_mask are sampled every cycle. A change takes effect on the next edge, including mid-SCAN.
- nib_in changes mid-SCAN appear on seg one cycle later. There is no latching per digit.
- en_mask=8'h00: anode stays 8'hFF permanently; sel still cycles.
- Reset asserted mid-SCAN or mid-BLANK: the next edge restores all reset values. No partial digit period completes.
- At most one anode bit is ever 0 in any cycle.
- No anode bit is 0 in the cycle where sel changes.

Test Plan (REFRESH_DIV=4, BLANK_CYC=2, combinational 32-bit nibble mux in bench with data=32'h8765_43F0):
- Reset held 3 cycles, then released -> during reset anode=FF, seg=7F, dp=1, sel=0. First 2 cycles after release anode=FF. Cycle 3: anode=FE, seg=1000000 ('0'), held 4 cycles.
- Free run for one full frame (48 cycles) -> sel steps 0..7 then wraps to 0. Digit 1 shows F (0001110) with anode=FD; digit 7 shows 8 (0000000) with anode=7F. Each lit window is 4 cycles, separated by 2 cycles of anode=FF.
- en_mask=8'b1111_1011 -> digit 2 window keeps anode=FF while sel=2; other digits light normally.
- dp_mask=8'h80 -> dp=0 only while anode=7F; dp=1 in all other cycles, including BLANK.
- Reset pulsed for 1 cycle during digit 5 SCAN -> next edge gives sel=0, anode=FF, state BLANK. Digit 0 lights 2 cycles later.
- Checker for the whole run -> never more than one anode low; anode never low on a cycle where sel differs from the previous cycle; all 16 nibble values are decoded correctly (sweep data across runs).
